// File: rtl/addsub_settle_meter.sv
// Stimulus driver and settle monitor for a ripple-carry add/subtract datapath.
// Launches one operation, computes the golden result and times the first stable run of sums.
module addsub_settle_meter #(
  parameter int WIDTH      = 16,
  parameter int STABLE_CNT = 20,
  parameter int TIMEOUT    = 500,
  parameter int CNT_W      = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_m,
  output logic [WIDTH-1:0] drv_a,
  output logic [WIDTH-1:0] drv_b,
  output logic             drv_m,
  input  logic [WIDTH-1:0] dut_s,
  input  logic             dut_c15,
  input  logic             dut_v,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] settle_cycles,
  output logic             flag_err,
  output logic [WIDTH-1:0] exp_s
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] STABLE_N  = CNT_W'(STABLE_CNT);
  localparam logic [CNT_W-1:0] TIMEOUT_N = CNT_W'(TIMEOUT);

  state_t           state, state_next;
  logic [CNT_W-1:0] k, match, k_inc, match_inc;
  logic             exp_c, exp_v;
  logic [WIDTH-1:0] b_x;
  logic [WIDTH:0]   full;
  logic [WIDTH-1:0] low;
  logic             settled, expired;

  always_comb begin
    b_x       = op_b ^ {WIDTH{op_m}};
    full      = {1'b0, op_a} + {1'b0, b_x} + {{WIDTH{1'b0}}, op_m};
    // low[WIDTH-1] is the carry into the MSB, needed for overflow
    low       = {1'b0, op_a[WIDTH-2:0]} + {1'b0, b_x[WIDTH-2:0]} + {{(WIDTH-1){1'b0}}, op_m};
    k_inc     = k + CNT_W'(1);
    match_inc = (dut_s == exp_s) ? match + CNT_W'(1) : '0;
    settled   = (match_inc == STABLE_N);
    expired   = (k_inc == TIMEOUT_N);
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (settled || expired) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drv_a         <= '0;
      drv_b         <= '0;
      drv_m         <= 1'b0;
      exp_s         <= '0;
      exp_c         <= 1'b0;
      exp_v         <= 1'b0;
      k             <= '0;
      match         <= '0;
      timeout       <= 1'b0;
      settle_cycles <= '0;
      flag_err      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          drv_a    <= op_a;
          drv_b    <= op_b;
          drv_m    <= op_m;
          exp_s    <= full[WIDTH-1:0];
          exp_c    <= full[WIDTH];
          exp_v    <= low[WIDTH-1] ^ full[WIDTH];
          k        <= '0;
          match    <= '0;
          timeout  <= 1'b0;
          flag_err <= 1'b0;
        end
        RUN: begin
          k     <= k_inc;
          match <= match_inc;
          // a stable run completing on the last allowed sample beats the timeout
          if (settled) begin
            settle_cycles <= k_inc - STABLE_N + CNT_W'(1);
            flag_err      <= (dut_c15 != exp_c) | (dut_v != exp_v);
          end else if (expired) begin
            timeout       <= 1'b1;
            settle_cycles <= '0;
            flag_err      <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_settle_meter.sv
// Self-checking bench: behavioural adder models (combinational, pipelined, stuck, glitching)
// drive the meter; expectations come from a plain-arithmetic reference and a window scan.
module tb_addsub_settle_meter;

  localparam int TO = 500;
  localparam int SC = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] op_a = '0, op_b = '0;
  logic        op_m = 1'b0;
  logic [15:0] drv_a, drv_b, dut_s, exp_s;
  logic        drv_m, dut_c15, dut_v, busy, done, timeout, flag_err;
  logic [9:0]  settle_cycles;

  addsub_settle_meter #(.WIDTH(16), .STABLE_CNT(SC), .TIMEOUT(TO), .CNT_W(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b), .op_m(op_m),
    .drv_a(drv_a), .drv_b(drv_b), .drv_m(drv_m), .dut_s(dut_s), .dut_c15(dut_c15),
    .dut_v(dut_v), .busy(busy), .done(done), .timeout(timeout),
    .settle_cycles(settle_cycles), .flag_err(flag_err), .exp_s(exp_s)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // returns {v, c, s} from integer arithmetic on the operand values
  function automatic logic [17:0] ref_op(input logic [15:0] a, input logic [15:0] b, input logic m);
    int sa, sb, r;
    logic c;
    logic [15:0] s;
    sa = $signed(a);
    sb = $signed(b);
    if (!m) begin
      s = 16'(int'(a) + int'(b));
      c = (int'(a) + int'(b)) > 65535;
      r = sa + sb;
    end else begin
      s = 16'(int'(a) - int'(b));
      c = (a >= b);
      r = sa - sb;
    end
    return {(r > 32767 || r < -32768), c, s};
  endfunction

  // adder models driven by the meter's drv_* outputs
  int          mode = 0;
  int          glitch_at = 0;
  bit          bad_v = 1'b0;
  int          samp = 0;
  logic [17:0] comb_out, p1, p2, p3, model_out;

  assign comb_out = ref_op(drv_a, drv_b, drv_m);

  always_ff @(posedge clk) begin
    p1 <= comb_out;
    p2 <= p1;
    p3 <= p2;
  end

  always_comb begin
    model_out = (mode == 0) ? comb_out : (mode == 1) ? p3 : {comb_out[17:16], 16'h1234};
    if (glitch_at != 0 && samp + 1 == glitch_at) model_out[15:0] = ~model_out[15:0];
    if (bad_v) model_out[17] = ~model_out[17];
  end

  assign dut_s   = model_out[15:0];
  assign dut_c15 = model_out[16];
  assign dut_v   = model_out[17];

  bit         hit [1:TO+40];
  logic [1:0] cv  [1:TO+40];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic m,
                        input int md, input int g, input bit bv, input int poke,
                        input int want_settle, input string tag);
    logic [17:0] r;
    bit          got;
    int          first, last;
    bit          all_ok, eflag;
    r = ref_op(a, b, m);
    for (int i = 1; i <= TO + 40; i++) begin hit[i] = 1'b0; cv[i] = 2'b00; end
    mode = md; glitch_at = g; bad_v = bv; samp = 0;
    @(negedge clk);
    op_a = a; op_b = b; op_m = m; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    got = 1'b0;
    while (!got && samp < TO + 30) begin
      @(negedge clk);
      hit[samp+1] = (dut_s === r[15:0]);
      cv[samp+1]  = {dut_v, dut_c15};
      @(posedge clk); #1;
      samp++;
      if (samp == poke) begin start = 1'b1; op_a = ~a; op_b = ~b; op_m = ~m; end
      else start = 1'b0;
      if (done === 1'b1) got = 1'b1;
    end
    start = 1'b0;
    // first window of SC consecutive matching samples within the budget
    first = 0;
    for (int i = 1; i + SC - 1 <= TO && first == 0; i++) begin
      all_ok = 1'b1;
      for (int j = 0; j < SC; j++) if (!hit[i+j]) all_ok = 1'b0;
      if (all_ok) first = i;
    end
    last  = (first != 0) ? first + SC - 1 : TO;
    eflag = (first != 0) && (cv[last] !== {r[17], r[16]});
    chk({tag, " done_seen"}, 32'(got), 32'd1);
    chk({tag, " done_at"}, samp, last);
    chk({tag, " timeout"}, 32'(timeout), 32'(first == 0));
    chk({tag, " settle"}, 32'(settle_cycles), first);
    if (want_settle >= 0) chk({tag, " settle_plan"}, 32'(settle_cycles), want_settle);
    chk({tag, " exp_s"}, 32'(exp_s), 32'(r[15:0]));
    chk({tag, " flag_err"}, 32'(flag_err), 32'(eflag));
    chk({tag, " drv"}, {15'd0, drv_m, drv_a}, {15'd0, m, a});
    @(posedge clk); #1;
    chk({tag, " done_pulse"}, {30'd0, done, busy}, 32'd0);
    @(posedge clk); #1;
    chk({tag, " idle_after"}, {30'd0, done, busy}, 32'd0);
  endtask

  initial begin
    #1;
    chk("reset_ctl", {28'd0, busy, done, timeout, flag_err}, 32'd0);
    chk("reset_data", {drv_a, drv_b}, 32'd0);
    chk("reset_res", {5'd0, drv_m, settle_cycles, exp_s}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op(16'd3, 16'd5, 1'b0, 0, 0, 1'b0, -1, 1, "comb_add");
    chk("comb_add exp_val", 32'(exp_s), 32'h0008);
    run_op(16'd99, 16'd1, 1'b1, 1, 0, 1'b0, -1, 4, "pipe_sub");
    chk("pipe_sub exp_val", 32'(exp_s), 32'h0062);
    run_op(16'hFFFF, 16'h0001, 1'b0, 0, 0, 1'b0, -1, 1, "wrap_add");
    chk("wrap_add exp_val", 32'(exp_s), 32'h0000);
    run_op(16'h7FFF, 16'hFFFF, 1'b1, 0, 0, 1'b0, -1, 1, "ovf_sub");
    chk("ovf_sub exp_val", 32'(exp_s), 32'h8000);
    run_op(16'h7FFF, 16'hFFFF, 1'b1, 0, 0, 1'b1, -1, 1, "bad_v");
    chk("bad_v flag", 32'(flag_err), 32'd1);
    run_op(16'h0100, 16'h0023, 1'b0, 0, 10, 1'b0, -1, 11, "glitch");
    run_op(16'h1111, 16'h2222, 1'b0, 2, 0, 1'b0, 100, 0, "stuck");

    for (int n = 0; n < 6; n++) begin
      run_op(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 1)),
             int'($urandom_range(0, 30)), ($urandom_range(0, 3) == 0), -1, -1,
             $sformatf("rand%0d", n));
    end

    // reset in the middle of a run
    mode = 2; glitch_at = 0; bad_v = 1'b0; samp = 0;
    @(negedge clk);
    op_a = 16'd3; op_b = 16'd5; op_m = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (50) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_ctl", {28'd0, busy, done, timeout, flag_err}, 32'd0);
    chk("midrst_data", {drv_a, drv_b}, 32'd0);
    chk("midrst_res", {5'd0, drv_m, settle_cycles, exp_s}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("midrst_nodone", {31'd0, done}, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(16'd3, 16'd5, 1'b0, 0, 0, 1'b0, -1, 1, "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
